// File: rtl/dist_search_ctrl_pkg.sv
// Shared types and constants for the distance-search controller and its best tracker.
// Distance width follows the dist_calc operand width.
package dist_search_ctrl_pkg;

   localparam int NUMBER_BITS = 37;
   localparam int DIST_W      = 2 * (NUMBER_BITS + 3) + 1;

   typedef logic signed [DIST_W-1:0] dist_t;

   localparam dist_t DIST_MAX = {1'b0, {(DIST_W-1){1'b1}}};

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      REQ,
      WAIT,
      CMP,
      DONE
   } search_state_t;

endpackage

// File: rtl/dist_search_ctrl_best_tracker.sv
// Running minimum of candidate distances with its index, plus the early-exit threshold compare.
// Ties keep the stored (lower) index because the update compare is strict.
module best_tracker
   import dist_search_ctrl_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             upd_en_i,
   input  dist_t            cand_dist_i,
   input  logic [IDX_W-1:0] cand_idx_i,
   input  dist_t            threshold_i,
   output dist_t            best_dist2_o,
   output logic [IDX_W-1:0] best_idx_o,
   output logic             thr_hit_o
);

   dist_t            best_dist2_q, best_dist2_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             better;
   dist_t            merged_dist;

   // thr_hit_o reflects the best value as it will be after this cycle's update.
   assign better      = (cand_dist_i < best_dist2_q);
   assign merged_dist = better ? cand_dist_i : best_dist2_q;
   assign thr_hit_o   = (merged_dist < threshold_i);

   always_comb begin
      best_dist2_d = best_dist2_q;
      best_idx_d   = best_idx_q;
      if (clear_i) begin
         best_dist2_d = DIST_MAX;
         best_idx_d   = '0;
      end else if (upd_en_i && better) begin
         best_dist2_d = cand_dist_i;
         best_idx_d   = cand_idx_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         best_dist2_q <= DIST_MAX;
         best_idx_q   <= '0;
      end else begin
         best_dist2_q <= best_dist2_d;
         best_idx_q   <= best_idx_d;
      end
   end

   assign best_dist2_o = best_dist2_q;
   assign best_idx_o   = best_idx_q;

endmodule

// File: rtl/dist_search_ctrl.sv
// Initiator for dist_calc: scans candidate indices, requests one distance per index and
// keeps the minimum; stops on threshold hit, end of list or response timeout.
module dist_search_ctrl
   import dist_search_ctrl_pkg::*;
#(
   parameter int IDX_W       = 8,
   parameter int ROM_LATENCY = 1,
   parameter int TIMEOUT     = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W:0]   num_candidates,
   input  dist_t            threshold,
   output logic [IDX_W-1:0] cand_idx,
   output logic             calc_ready,
   input  dist_t            calc_dist2,
   input  logic             calc_finished,
   output logic             busy,
   output logic             done,
   output logic             hit,
   output logic             timeout_err,
   output logic [IDX_W-1:0] best_idx,
   output dist_t            best_dist2,
   output search_state_t    state_dbg
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   // calc_ready is a one-cycle request; calc_finished is only accepted in WAIT, so a
   // level left high from an earlier transaction cannot complete the next request early.
   search_state_t    state_q, state_d;
   logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
   logic [IDX_W:0]   num_q, num_d;
   dist_t            thr_q, thr_d;
   dist_t            dist_q, dist_d;
   logic [2:0]       rom_cnt_q, rom_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             hit_q, hit_d;
   logic             tmo_err_q, tmo_err_d;
   logic             trk_clear, trk_upd, trk_thr_hit;
   logic             last_cand;

   assign last_cand = ({1'b0, cand_idx_q} == (num_q - (IDX_W+1)'(1)));

   always_comb begin
      state_d    = state_q;
      cand_idx_d = cand_idx_q;
      num_d      = num_q;
      thr_d      = thr_q;
      dist_d     = dist_q;
      rom_cnt_d  = rom_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      hit_d      = hit_q;
      tmo_err_d  = tmo_err_q;
      trk_clear  = 1'b0;
      trk_upd    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               trk_clear  = 1'b1;
               hit_d      = 1'b0;
               tmo_err_d  = 1'b0;
               cand_idx_d = '0;
               if (num_candidates == '0) begin
                  state_d = DONE;
               end else begin
                  num_d     = num_candidates;
                  thr_d     = threshold;
                  rom_cnt_d = '0;
                  state_d   = FETCH;
               end
            end
         end
         FETCH: begin
            // FETCH spans ROM_LATENCY cycles (minimum one) after cand_idx settles.
            if (({1'b0, rom_cnt_q} + 4'd1) >= 4'(ROM_LATENCY)) begin
               rom_cnt_d = '0;
               state_d   = REQ;
            end else begin
               rom_cnt_d = rom_cnt_q + 3'd1;
            end
         end
         REQ: begin
            tmo_cnt_d = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (calc_finished) begin
               dist_d  = calc_dist2;
               state_d = CMP;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               tmo_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         CMP: begin
            trk_upd = 1'b1;
            if (trk_thr_hit) begin
               hit_d   = 1'b1;
               state_d = DONE;
            end else if (last_cand) begin
               state_d = DONE;
            end else begin
               cand_idx_d = cand_idx_q + 1'b1;
               rom_cnt_d  = '0;
               state_d    = FETCH;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cand_idx_q <= '0;
         num_q      <= '0;
         thr_q      <= '0;
         dist_q     <= '0;
         rom_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         hit_q      <= 1'b0;
         tmo_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cand_idx_q <= cand_idx_d;
         num_q      <= num_d;
         thr_q      <= thr_d;
         dist_q     <= dist_d;
         rom_cnt_q  <= rom_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         hit_q      <= hit_d;
         tmo_err_q  <= tmo_err_d;
      end
   end

   best_tracker #(
      .IDX_W(IDX_W)
   ) u_best (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (trk_clear),
      .upd_en_i     (trk_upd),
      .cand_dist_i  (dist_q),
      .cand_idx_i   (cand_idx_q),
      .threshold_i  (thr_q),
      .best_dist2_o (best_dist2),
      .best_idx_o   (best_idx),
      .thr_hit_o    (trk_thr_hit)
   );

   assign cand_idx    = cand_idx_q;
   assign calc_ready  = (state_q == REQ);
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = (state_q == DONE);
   assign hit         = hit_q;
   assign timeout_err = tmo_err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_dist_search_ctrl.sv
// Directed bench for dist_search_ctrl with a latency-programmable dist_calc model,
// an expected-result queue and two extra instances sweeping ROM_LATENCY.
module tb_dist_search_ctrl;
   import dist_search_ctrl_pkg::*;

   localparam int IDX_W   = 8;
   localparam int TIMEOUT = 64;
   localparam int EXP_W   = 2 + IDX_W + DIST_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [IDX_W:0]   num_candidates = '0;
   dist_t            threshold = '0;
   logic [IDX_W-1:0] cand_idx;
   logic             calc_ready;
   dist_t            calc_dist2 = '0;
   logic             calc_finished = 1'b0;
   logic             busy, done, hit, timeout_err;
   logic [IDX_W-1:0] best_idx;
   dist_t            best_dist2;
   search_state_t    state_dbg;

   dist_search_ctrl #(
      .IDX_W(IDX_W), .ROM_LATENCY(1), .TIMEOUT(TIMEOUT)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .num_candidates(num_candidates),
      .threshold(threshold), .cand_idx(cand_idx), .calc_ready(calc_ready),
      .calc_dist2(calc_dist2), .calc_finished(calc_finished), .busy(busy), .done(done),
      .hit(hit), .timeout_err(timeout_err), .best_idx(best_idx), .best_dist2(best_dist2),
      .state_dbg(state_dbg)
   );

   // ---------------- dist_calc model and monitors ----------------
   dist_t resp_q[$];
   int    model_lat = 4;
   bit    mute = 1'b0;
   bit    pend = 1'b0;
   int    pend_cnt = 0;
   int    cyc = 0;
   int    ready_cnt = 0, done_cnt = 0, ready_cyc = 0, done_cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      calc_finished = 1'b0;
      if (reset) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               pend = 1'b0;
               calc_finished = 1'b1;
               calc_dist2 = (resp_q.size() > 0) ? resp_q.pop_front() : DIST_MAX;
            end
         end
         if (calc_ready && !mute) begin
            pend = 1'b1;
            pend_cnt = model_lat;
         end
      end
      if (calc_ready) begin ready_cnt++; ready_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
   end

   // ---------------- ROM_LATENCY sweep instances (0 and 3) ----------------
   for (genvar g = 0; g < 2; g++) begin : g_sweep
      logic [IDX_W-1:0] s_idx, s_best_idx;
      logic             s_ready, s_busy, s_done, s_hit, s_to;
      logic             s_fin = 1'b0;
      dist_t            s_dist = '0;
      dist_t            s_best;
      search_state_t    s_state;
      int               s_fc = 0, s_cnt = 0, s_gap = -1;
      logic [IDX_W-1:0] s_prev = '0;

      dist_search_ctrl #(
         .IDX_W(IDX_W), .ROM_LATENCY(3 * g), .TIMEOUT(TIMEOUT)
      ) u_sweep (
         .clk(clk), .reset(reset), .start(start), .num_candidates(num_candidates),
         .threshold(threshold), .cand_idx(s_idx), .calc_ready(s_ready),
         .calc_dist2(s_dist), .calc_finished(s_fin), .busy(s_busy), .done(s_done),
         .hit(s_hit), .timeout_err(s_to), .best_idx(s_best_idx), .best_dist2(s_best),
         .state_dbg(s_state)
      );

      // Gap = cycles from first cycle with a new cand_idx to its calc_ready.
      always @(negedge clk) begin
         s_fin = 1'b0;
         if (reset) begin
            s_fc = 0;
         end else begin
            if (s_fc > 0) begin
               s_fc--;
               if (s_fc == 0) begin
                  s_fin  = 1'b1;
                  s_dist = dist_t'(1000) - dist_t'(s_idx);
               end
            end
            if (s_ready) s_fc = 2;
         end
         if (s_idx != s_prev) s_cnt = 0;
         else s_cnt++;
         s_prev = s_idx;
         if (s_ready && s_idx != '0) s_gap = s_cnt;
      end
   end

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_search(input string tag, input int num, input dist_t thr,
                             input bit exp_to, input int poke_at);
      dist_t            best = DIST_MAX;
      int               bi = 0, reqs = 0, r0, d0, start_cyc, k;
      bit               h = 1'b0;
      logic [EXP_W-1:0] e;
      if (exp_to) begin
         reqs = (num > 0) ? 1 : 0;
      end else begin
         for (int i = 0; i < num; i++) begin
            reqs++;
            if (resp_q[i] < best) begin best = resp_q[i]; bi = i; end
            if (best < thr) begin h = 1'b1; break; end
         end
      end
      exp_q.push_back({h, exp_to, IDX_W'(bi), best});
      r0 = ready_cnt;
      d0 = done_cnt;
      @(negedge clk);
      num_candidates = (IDX_W+1)'(num);
      threshold = thr;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, (num > 0));
      k = 0;
      while (k < 3000 && done_cnt == d0) begin
         if (k == poke_at) begin
            num_candidates = 1;
            threshold = DIST_MAX;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check({tag, "_done_pulses"}, done_cnt - d0, 1);
      e = exp_q.pop_front();
      check({tag, "_best_dist2"}, best_dist2, e[DIST_W-1:0]);
      check({tag, "_best_idx"}, best_idx, e[DIST_W +: IDX_W]);
      check({tag, "_timeout_err"}, timeout_err, e[EXP_W-2]);
      check({tag, "_hit"}, hit, e[EXP_W-1]);
      check({tag, "_requests"}, ready_cnt - r0, reqs);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      if (num == 0) check({tag, "_done_latency"}, done_cyc - start_cyc, 1);
      @(negedge clk);
      check({tag, "_done_single_cycle"}, done, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_calc_ready"}, calc_ready, 1'b0);
      check({tag, "_cand_idx"}, cand_idx, 0);
      check({tag, "_hit"}, hit, 1'b0);
      check({tag, "_timeout_err"}, timeout_err, 1'b0);
      check({tag, "_best_idx"}, best_idx, 0);
      check({tag, "_best_dist2"}, best_dist2, DIST_MAX);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int r0, d0, k;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);

      // 1: full scan, minimum in the middle; sweep instances run alongside.
      resp_q = '{dist_t'(500), dist_t'(200), dist_t'(300)};
      run_search("scan3", 3, dist_t'(0), 1'b0, -1);
      k = 0;
      while (k < 500 && (g_sweep[0].s_busy || g_sweep[1].s_busy)) begin
         @(negedge clk);
         k++;
      end
      check("sweep_idle", {g_sweep[0].s_busy, g_sweep[1].s_busy}, 2'b00);
      check("rom_lat0_gap", g_sweep[0].s_gap, 1);
      check("rom_lat3_gap", g_sweep[1].s_gap, 3);
      check("rom_lat3_best", g_sweep[1].s_best_idx, 2);

      // 2: threshold hit stops early.
      resp_q = '{dist_t'(400), dist_t'(240), dist_t'(100), dist_t'(50)};
      run_search("thr_hit", 4, dist_t'(250), 1'b0, -1);
      resp_q.delete();

      // 3: tie keeps the lower index.
      resp_q = '{dist_t'(100), dist_t'(100)};
      run_search("tie", 2, dist_t'(0), 1'b0, -1);

      // 4: no response -> timeout 64 cycles after WAIT entry.
      mute = 1'b1;
      run_search("timeout", 2, dist_t'(0), 1'b1, -1);
      check("timeout_cycles", done_cyc - (ready_cyc + 1), TIMEOUT);
      mute = 1'b0;

      // 5: empty list, then start pulsed while busy.
      run_search("empty", 0, dist_t'(1000), 1'b0, -1);
      resp_q = '{dist_t'(700), dist_t'(90), dist_t'(600)};
      run_search("start_busy", 3, dist_t'(0), 1'b0, 6);

      // 6: reset in WAIT of the second candidate.
      resp_q = '{dist_t'(300)};
      r0 = ready_cnt;
      d0 = done_cnt;
      @(negedge clk);
      num_candidates = 2;
      threshold = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (k < 200 && ready_cnt == r0) begin @(negedge clk); k++; end
      @(negedge clk);
      mute = 1'b1;
      k = 0;
      while (k < 200 && ready_cnt < r0 + 2) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      check("mid_wait_cand_idx", cand_idx, 1);
      check("mid_wait_best_dist2", best_dist2, dist_t'(300));
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("reset_mid_wait");
      reset = 1'b0;
      mute = 1'b0;
      repeat (TIMEOUT + 10) @(negedge clk);
      check("reset_no_done", done_cnt - d0, 0);
      resp_q = '{dist_t'(800), dist_t'(20)};
      run_search("after_reset", 2, dist_t'(0), 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
